// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcodes, EX/MEM payload layout and the bubble value.
package pipeline_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned FUNCT3_W = 3;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_W    = 5;

  localparam logic [OPCODE_W-1:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPCODE_STORE = 7'b0100011;

  // Payload carried from EX into MEM.
  typedef struct packed {
    logic                valid;
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT3_W-1:0] funct3;
    logic [XLEN-1:0]     b;
    logic [XLEN-1:0]     c;
    logic [REG_W-1:0]    rd;
    logic                reg_write;
  } pipe_payload_t;

  // A bubble is an all-zero payload: not valid, opcode 0, no register write.
  localparam pipe_payload_t BUBBLE = '0;

  // True for opcodes that access data memory.
  function automatic logic is_mem_opcode(input logic [OPCODE_W-1:0] opcode);
    return (opcode == OPCODE_LOAD) || (opcode == OPCODE_STORE);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Counts consecutive memory-stall cycles (saturating) and raises a sticky timeout.
//   clk, rst    : clock, synchronous active-high reset
//   stall       : memory stall active this cycle
//   wait_count  : consecutive stalled edges, cleared on any unstalled edge
//   mem_timeout : set when wait_count reaches TIMEOUT (TIMEOUT=0 disables), held until reset
module mem_wait_counter #(
  parameter int unsigned WAIT_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  output logic [WAIT_W-1:0] wait_count,
  output logic              mem_timeout
);

  localparam logic [WAIT_W-1:0] COUNT_MAX  = '1;
  localparam logic              TIMEOUT_EN = (TIMEOUT != 0);
  // Count value from which the next stalled edge lands on TIMEOUT.
  localparam logic [WAIT_W-1:0] TIMEOUT_M1 = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [WAIT_W-1:0] count_nxt;
  logic              timeout_nxt;

  // Next-state: saturating increment while stalled, clear otherwise.
  always_comb begin
    count_nxt   = '0;
    timeout_nxt = mem_timeout;
    if (stall) begin
      count_nxt = (wait_count == COUNT_MAX) ? wait_count : wait_count + WAIT_W'(1);
      if (TIMEOUT_EN && (wait_count == TIMEOUT_M1)) begin
        timeout_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_count  <= '0;
      mem_timeout <= 1'b0;
    end else begin
      wait_count  <= count_nxt;
      mem_timeout <= timeout_nxt;
    end
  end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with memory-stall hold, flush-to-bubble and wait supervision.
//   clk, rst          : clock, synchronous active-high reset
//   ex_*              : instruction fields from EX
//   flush             : kill the instruction in EX (deferred while stalled)
//   data_mem_ready_n  : 0 = data memory ready
//   mem_*             : registered instruction fields to MEM
//   mem_stall         : combinational stall request to IF/ID/EX and this register
//   wait_count        : consecutive stall cycles (saturating)
//   mem_timeout       : sticky timeout flag
module ex_mem_reg
  import pipeline_pkg::*;
#(
  parameter int unsigned WAIT_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  input  logic [OPCODE_W-1:0] ex_opcode,
  input  logic [FUNCT3_W-1:0] ex_funct3,
  input  logic [XLEN-1:0]     ex_b,
  input  logic [XLEN-1:0]     ex_c,
  input  logic [REG_W-1:0]    ex_rd,
  input  logic                ex_reg_write,
  input  logic                flush,
  input  logic                data_mem_ready_n,
  output logic                mem_valid,
  output logic [OPCODE_W-1:0] mem_opcode,
  output logic [FUNCT3_W-1:0] mem_funct3,
  output logic [XLEN-1:0]     mem_b,
  output logic [XLEN-1:0]     mem_c,
  output logic [REG_W-1:0]    mem_rd,
  output logic                mem_reg_write,
  output logic                mem_stall,
  output logic [WAIT_W-1:0]   wait_count,
  output logic                mem_timeout
);

  pipe_payload_t q;
  pipe_payload_t q_nxt;
  pipe_payload_t ex_payload;
  logic          pending_flush;
  logic          pending_flush_nxt;

  assign ex_payload = '{valid:     ex_valid,
                        opcode:    ex_opcode,
                        funct3:    ex_funct3,
                        b:         ex_b,
                        c:         ex_c,
                        rd:        ex_rd,
                        reg_write: ex_reg_write};

  // Only a valid load/store in MEM can stall; bubbles with a LOAD opcode never do.
  assign mem_stall = q.valid && is_mem_opcode(q.opcode) && data_mem_ready_n;

  // Next-state: hold while stalled (remembering any flush), else capture or bubble.
  always_comb begin
    q_nxt             = q;
    pending_flush_nxt = pending_flush;
    if (mem_stall) begin
      // The MEM instruction is older than the flushed one, so it stays.
      pending_flush_nxt = pending_flush | flush;
    end else if (flush || pending_flush) begin
      q_nxt             = BUBBLE;
      pending_flush_nxt = 1'b0;
    end else begin
      q_nxt = ex_payload;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q             <= BUBBLE;
      pending_flush <= 1'b0;
    end else begin
      q             <= q_nxt;
      pending_flush <= pending_flush_nxt;
    end
  end

  assign mem_valid     = q.valid;
  assign mem_opcode    = q.opcode;
  assign mem_funct3    = q.funct3;
  assign mem_b         = q.b;
  assign mem_c         = q.c;
  assign mem_rd        = q.rd;
  assign mem_reg_write = q.reg_write;

  mem_wait_counter #(
    .WAIT_W  (WAIT_W),
    .TIMEOUT (TIMEOUT)
  ) u_mem_wait_counter (
    .clk         (clk),
    .rst         (rst),
    .stall       (mem_stall),
    .wait_count  (wait_count),
    .mem_timeout (mem_timeout)
  );

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed testbench for ex_mem_reg with hand-computed expectations.
module tb_ex_mem_reg;

  localparam int unsigned WAIT_W  = 8;
  localparam int unsigned TIMEOUT = 4;

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_ADDI  = 7'h13;
  localparam logic [6:0] OP_ADD   = 7'h33;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid;
  logic [6:0]        ex_opcode;
  logic [2:0]        ex_funct3;
  logic [31:0]       ex_b;
  logic [31:0]       ex_c;
  logic [4:0]        ex_rd;
  logic              ex_reg_write;
  logic              flush;
  logic              data_mem_ready_n;
  logic              mem_valid;
  logic [6:0]        mem_opcode;
  logic [2:0]        mem_funct3;
  logic [31:0]       mem_b;
  logic [31:0]       mem_c;
  logic [4:0]        mem_rd;
  logic              mem_reg_write;
  logic              mem_stall;
  logic [WAIT_W-1:0] wait_count;
  logic              mem_timeout;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ex_mem_reg #(
    .WAIT_W  (WAIT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ex_valid         (ex_valid),
    .ex_opcode        (ex_opcode),
    .ex_funct3        (ex_funct3),
    .ex_b             (ex_b),
    .ex_c             (ex_c),
    .ex_rd            (ex_rd),
    .ex_reg_write     (ex_reg_write),
    .flush            (flush),
    .data_mem_ready_n (data_mem_ready_n),
    .mem_valid        (mem_valid),
    .mem_opcode       (mem_opcode),
    .mem_funct3       (mem_funct3),
    .mem_b            (mem_b),
    .mem_c            (mem_c),
    .mem_rd           (mem_rd),
    .mem_reg_write    (mem_reg_write),
    .mem_stall        (mem_stall),
    .wait_count       (wait_count),
    .mem_timeout      (mem_timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] b, input logic [31:0] c,
                        input logic [4:0] rd, input logic rw);
    ex_valid     = v;
    ex_opcode    = op;
    ex_funct3    = f3;
    ex_b         = b;
    ex_c         = c;
    ex_rd        = rd;
    ex_reg_write = rw;
  endtask

  initial begin
    rst              = 1'b1;
    flush            = 1'b0;
    data_mem_ready_n = 1'b0;
    set_ex(1'b0, 7'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset / idle
    check_eq("rst_valid",   32'(mem_valid),     32'h0);
    check_eq("rst_opcode",  32'(mem_opcode),    32'h0);
    check_eq("rst_c",       mem_c,              32'h0);
    check_eq("rst_rw",      32'(mem_reg_write), 32'h0);
    check_eq("rst_stall",   32'(mem_stall),     32'h0);
    check_eq("rst_wait",    32'(wait_count),    32'h0);
    check_eq("rst_timeout", 32'(mem_timeout),   32'h0);

    // ADDI captured with 1-cycle latency
    set_ex(1'b1, OP_ADDI, 3'd0, 32'h0, 32'h10, 5'd1, 1'b1);
    tick();
    check_eq("addi_opcode", 32'(mem_opcode), 32'h13);
    check_eq("addi_c",      mem_c,           32'h10);
    check_eq("addi_valid",  32'(mem_valid),  32'h1);
    check_eq("addi_rd",     32'(mem_rd),     32'h1);

    // LOAD stalled for 3 cycles
    set_ex(1'b1, OP_LOAD, 3'd2, 32'h0, 32'h100, 5'd5, 1'b1);
    data_mem_ready_n = 1'b1;
    tick();
    set_ex(1'b1, OP_ADDI, 3'd0, 32'h0, 32'h200, 5'd6, 1'b1);
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("ld_stall%0d", i), 32'(mem_stall),  32'h1);
      check_eq($sformatf("ld_c%0d", i),     mem_c,           32'h100);
      check_eq($sformatf("ld_wait%0d", i),  32'(wait_count), 32'(i));
      tick();
    end
    data_mem_ready_n = 1'b0;
    #1;
    check_eq("ld_rel_stall",  32'(mem_stall),  32'h0);
    check_eq("ld_rel_wait",   32'(wait_count), 32'h3);
    check_eq("ld_rel_funct3", 32'(mem_funct3), 32'h2);
    tick();
    check_eq("ld_next_c",     mem_c,            32'h200);
    check_eq("ld_next_wait",  32'(wait_count),  32'h0);
    check_eq("ld_no_timeout", 32'(mem_timeout), 32'h0);

    // Non-memory op never stalls
    set_ex(1'b1, OP_ADD, 3'd0, 32'h0, 32'h300, 5'd7, 1'b1);
    data_mem_ready_n = 1'b1;
    tick();
    check_eq("add_opcode", 32'(mem_opcode), 32'h33);
    check_eq("add_stall",  32'(mem_stall),  32'h0);
    ex_c = 32'h301;
    tick();
    check_eq("add_c2",     mem_c,           32'h301);
    check_eq("add_stall2", 32'(mem_stall),  32'h0);

    // Flush while not stalled
    set_ex(1'b1, OP_ADDI, 3'd0, 32'h0, 32'h55, 5'd8, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("fl_valid",  32'(mem_valid),     32'h0);
    check_eq("fl_rw",     32'(mem_reg_write), 32'h0);
    check_eq("fl_opcode", 32'(mem_opcode),    32'h0);
    check_eq("fl_c",      mem_c,              32'h0);

    // Flush pulsed during a 2-cycle STORE stall
    set_ex(1'b1, OP_STORE, 3'd2, 32'hdead, 32'h400, 5'd0, 1'b0);
    tick();
    check_eq("st_stall0", 32'(mem_stall), 32'h1);
    set_ex(1'b1, OP_ADDI, 3'd0, 32'h0, 32'h500, 5'd9, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check_eq("st_hold_op", 32'(mem_opcode), 32'h23);
    check_eq("st_hold_c",  mem_c,           32'h400);
    check_eq("st_stall1",  32'(mem_stall),  32'h1);
    check_eq("st_wait1",   32'(wait_count), 32'h1);
    tick();
    data_mem_ready_n = 1'b0;
    #1;
    check_eq("st_rel_stall", 32'(mem_stall), 32'h0);
    check_eq("st_rel_b",     mem_b,          32'hdead);
    tick();
    check_eq("st_bub_valid", 32'(mem_valid),  32'h0);
    check_eq("st_bub_op",    32'(mem_opcode), 32'h0);
    check_eq("st_bub_c",     mem_c,           32'h0);
    tick();
    check_eq("st_after_c",     mem_c,          32'h500);
    check_eq("st_after_valid", 32'(mem_valid), 32'h1);

    // LOAD stalled 6 cycles with TIMEOUT=4
    set_ex(1'b1, OP_LOAD, 3'd2, 32'h0, 32'h600, 5'd10, 1'b1);
    data_mem_ready_n = 1'b1;
    tick();
    set_ex(1'b1, OP_ADDI, 3'd0, 32'h0, 32'h700, 5'd11, 1'b1);
    #1;
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("to_wait%0d", i),  32'(wait_count),  32'(i));
      check_eq($sformatf("to_flag%0d", i),  32'(mem_timeout), (i >= 4) ? 32'h1 : 32'h0);
      check_eq($sformatf("to_stall%0d", i), 32'(mem_stall),   32'h1);
      tick();
    end
    data_mem_ready_n = 1'b0;
    tick();
    check_eq("to_rel_c",    mem_c,            32'h700);
    check_eq("to_rel_wait", 32'(wait_count),  32'h0);
    check_eq("to_sticky",   32'(mem_timeout), 32'h1);

    // Bubble carrying a LOAD opcode never stalls
    set_ex(1'b0, OP_LOAD, 3'd2, 32'h0, 32'h750, 5'd12, 1'b0);
    data_mem_ready_n = 1'b1;
    tick();
    check_eq("bub_ld_op",    32'(mem_opcode), 32'h03);
    check_eq("bub_ld_stall", 32'(mem_stall),  32'h0);

    // Reset in the 2nd cycle of a LOAD stall with a pending flush
    set_ex(1'b1, OP_LOAD, 3'd2, 32'h0, 32'h800, 5'd13, 1'b1);
    tick();
    check_eq("rs_stall0", 32'(mem_stall), 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check_eq("rs_stall1", 32'(mem_stall),  32'h1);
    check_eq("rs_wait1",  32'(wait_count), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("rs_valid",   32'(mem_valid),   32'h0);
    check_eq("rs_opcode",  32'(mem_opcode),  32'h0);
    check_eq("rs_c",       mem_c,            32'h0);
    check_eq("rs_stall",   32'(mem_stall),   32'h0);
    check_eq("rs_wait",    32'(wait_count),  32'h0);
    check_eq("rs_timeout", 32'(mem_timeout), 32'h0);
    // A surviving pending flush would turn this capture into a bubble.
    data_mem_ready_n = 1'b0;
    set_ex(1'b1, OP_ADDI, 3'd0, 32'h0, 32'h900, 5'd14, 1'b1);
    tick();
    check_eq("rs_post_c",     mem_c,          32'h900);
    check_eq("rs_post_valid", 32'(mem_valid), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- EX/MEM pipeline register with memory-stall control.
- Captures EX results (opcode, funct3, store data b, address c, rd, reg-write) and presents them to the MEM stage.
- Holds its contents while a load/store waits on data_mem_ready_n, and signals the stall upstream.
- Converts flushes into bubbles and supervises memory wait time with a saturating counter and a sticky timeout flag.

Parameters:
- WAIT_W, 8, width of the wait-cycle counter.
- TIMEOUT, 255, consecutive stall cycles that raise mem_timeout. 0 disables the timeout. Must be ≤ 2^WAIT_W−1.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- ex_valid  in  1  EX holds a real instruction.
- ex_opcode  in  7  EX opcode.
- ex_funct3  in  3  EX funct3.
- ex_b  in  32  store data.
- ex_c  in  32  ALU result / memory address.
- ex_rd  in  5  destination register.
- ex_reg_write  in  1  instruction writes rd.
- flush  in  1  kill the instruction currently in EX (branch/jump redirect).
- data_mem_ready_n  in  1  0 = memory ready, 1 = not ready.
- mem_valid  out  1  MEM-stage instruction valid.
- mem_opcode  out  7  to MEM stage.
- mem_funct3  out  3  to MEM stage.
- mem_b  out  32  to MEM stage.
- mem_c  out  32  to MEM stage.
- mem_rd  out  5  to MEM stage.
- mem_reg_write  out  1  to MEM stage.
- mem_stall  out  1  freeze IF/ID/EX and this register.
- wait_count  out  WAIT_W  consecutive stall cycles, saturating.
- mem_timeout  out  1  sticky timeout flag.

Behaviour:
- Reset (rst=1 at edge): all registered outputs 0, pending_flush=0. A register with opcode 0 and mem_valid=0 is a bubble. rst has priority over every other event.
- is_mem_op = mem_valid && (mem_opcode==7'b0000011 LOAD || mem_opcode==7'b0100011 STORE).
- mem_stall = is_mem_op && data_mem_ready_n. Combinational from registers plus ready_n, with no extra latency.
- Normal capture (mem_stall=0, no flush):
  - All mem_* outputs take the ex_* values.
  - mem_valid takes ex_valid.
  - Latency EX→MEM is 1 cycle.
- Flush capture (mem_stall=0 and (flush || pending_flush)):
  - Register loads a bubble: mem_valid=0, mem_reg_write=0, mem_opcode=0. Other fields are don't-care but must be zeroed.
  - pending_flush clears.
- Stall (mem_stall=1):
  - All mem_* registers hold.
  - flush does not disturb the MEM instruction, which is older.
  - flush=1 sets pending_flush. It stays set until the next non-stalled edge, which loads a bubble.
- Stall release: on the first cycle with data_mem_ready_n=0 the MEM instruction completes and the next EX instruction is captured at that edge.
- wait_count:
  - Increments each edge with mem_stall=1, saturating at 2^WAIT_W−1.
  - Clears to 0 on any edge with mem_stall=0.
- mem_timeout:
  - Set at the edge where wait_count transitions to TIMEOUT, with TIMEOUT≠0.
  - Stays 1 until reset.
  - The stall itself continues; the block never drops the instruction.
- A non-memory opcode never stalls, regardless of data_mem_ready_n.
- A bubble never stalls, even if it has a LOAD opcode.
- Back-to-back loads/stores: each stalls independently. wait_count restarts from 0 for the second access.
- Reset mid-stall: stall, wait_count, pending_flush and mem_timeout all clear at that edge.

Decomposition:
- Shared package (pipeline_pkg):
  - OPCODE_LOAD=7'b0000011, OPCODE_STORE=7'b0100011.
  - The BUBBLE field values.
  - Reused by mem_ctrl and the ID/EX register.
- One sub-module: mem_wait_counter (WAIT_W, TIMEOUT). Inputs clk, rst, stall; outputs wait_count, mem_timeout.

Test Plan:
- Reset then idle → all outputs 0, mem_stall=0. Drive ADDI (opcode 0010011, c=0x10) with ex_valid=1 → next cycle mem_opcode=0x13, mem_c=0x10, mem_valid=1.
- LOAD with c=0x100 and data_mem_ready_n=1 for 3 cycles, then 0 → mem_stall=1 for exactly 3 cycles, mem_c stays 0x100 while EX changes, wait_count goes 1,2,3 then 0, next EX instruction captured on the release edge.
- ADD (0110011) with data_mem_ready_n=1 → mem_stall=0, capture proceeds every cycle.
- flush=1 while not stalled → next cycle mem_valid=0, mem_reg_write=0. flush pulsed for 1 cycle during a 2-cycle STORE stall → STORE held, first post-release capture is a bubble.
- TIMEOUT=4 with LOAD stalled 6 cycles → mem_timeout rises on the edge where wait_count becomes 4, stays 1 after release, clears only on rst.
- rst asserted in the 2nd cycle of a LOAD stall → next cycle all outputs 0, mem_stall=0, pending_flush=0.
